// File: rtl/matrix_operand_loader.sv
// Operand loader for the systolic multiplier: streams A then B into a shadow
// bank and transfers the pair into a held output bank. The output bank drives
// the multiplier's a/b buses while the next pair loads into the shadow bank.
module matrix_operand_loader #(
    parameter int unsigned N        = 2,
    parameter int unsigned OP_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [OP_WIDTH-1:0]        in_data,
    output logic [N*N*OP_WIDTH-1:0]    a,
    output logic [N*N*OP_WIDTH-1:0]    b,
    output logic                       mat_valid,
    input  logic                       mat_ready,
    output logic                       start
);

    localparam int unsigned NN    = N * N;
    localparam int unsigned BUS_W = NN * OP_WIDTH;
    localparam int unsigned IDX_W = (NN > 1) ? $clog2(NN) : 1;

    typedef enum logic [1:0] {
        S_FILL_A = 2'd0,
        S_FILL_B = 2'd1,
        S_FULL   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_idx;
    logic [BUS_W-1:0]   r_sh_a;
    logic [BUS_W-1:0]   r_sh_b;
    logic [BUS_W-1:0]   r_a;
    logic [BUS_W-1:0]   r_b;
    logic               r_mat_valid;
    logic               r_start;

    logic               w_in_ready;
    logic               w_wr_a;
    logic               w_wr_b;
    logic               w_accept;
    logic               w_last;
    logic               w_xfer;

    assign w_accept = w_wr_a | w_wr_b;
    assign w_last   = (r_idx == IDX_W'(NN - 1));

    // Fill FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_FILL_A;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Fill FSM next state: advance on the last element of each matrix, free on transfer
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FILL_A: if (w_accept && w_last) w_state_nxt = S_FILL_B;
            S_FILL_B: if (w_accept && w_last) w_state_nxt = S_FULL;
            S_FULL:   if (w_xfer)             w_state_nxt = S_FILL_A;
            default:                          w_state_nxt = S_FILL_A;
        endcase
    end

    // Fill FSM outputs: handshake, shadow write enables and transfer strobe
    always_comb begin
        w_in_ready = 1'b0;
        w_wr_a     = 1'b0;
        w_wr_b     = 1'b0;
        w_xfer     = 1'b0;
        case (r_state)
            S_FILL_A: begin
                w_in_ready = reset_n;
                w_wr_a     = in_valid & reset_n;
            end
            S_FILL_B: begin
                w_in_ready = reset_n;
                w_wr_b     = in_valid & reset_n;
            end
            S_FULL: begin
                w_xfer = !r_mat_valid || mat_ready;
            end
            default: begin
                w_in_ready = 1'b0;
            end
        endcase
    end

    // Element index within the matrix being filled; cleared after the last element
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idx <= '0;
        end else if (w_accept) begin
            r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
        end
    end

    // Shadow bank: accepted element lands at the current row-major index
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sh_a <= '0;
            r_sh_b <= '0;
        end else begin
            for (int i = 0; i < NN; i++) begin
                if (w_wr_a && (r_idx == IDX_W'(i))) r_sh_a[i*OP_WIDTH +: OP_WIDTH] <= in_data;
                if (w_wr_b && (r_idx == IDX_W'(i))) r_sh_b[i*OP_WIDTH +: OP_WIDTH] <= in_data;
            end
        end
    end

    // Output bank: load on transfer, otherwise hold; valid drops on a plain consume
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a         <= '0;
            r_b         <= '0;
            r_mat_valid <= 1'b0;
            r_start     <= 1'b0;
        end else begin
            r_start <= w_xfer;
            if (w_xfer) begin
                r_a         <= r_sh_a;
                r_b         <= r_sh_b;
                r_mat_valid <= 1'b1;
            end else if (r_mat_valid && mat_ready) begin
                r_mat_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign a         = r_a;
    assign b         = r_b;
    assign mat_valid = r_mat_valid;
    assign start     = r_start;

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Bench for matrix_operand_loader: directed scenarios plus randomized streaming,
// with a negedge monitor checking against a queue of expected operand pairs.
module tb_matrix_operand_loader;

    localparam int unsigned N  = 2;
    localparam int unsigned W  = 8;
    localparam int unsigned NN = N * N;
    localparam int unsigned BW = NN * W;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [BW-1:0] a;
    logic [BW-1:0] b;
    logic          mat_valid;
    logic          mat_ready;
    logic          start;

    matrix_operand_loader #(.N(N), .OP_WIDTH(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .a         (a),
        .b         (b),
        .mat_valid (mat_valid),
        .mat_ready (mat_ready),
        .start     (start)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: accepted beats gathered into pairs; a pair is pending in
    // exp_q from completion until it is handed to the output bank.
    logic [W-1:0]    beats[$];
    logic [2*BW-1:0] exp_q[$];
    logic [BW-1:0]   held_a = '0;
    logic [BW-1:0]   held_b = '0;
    logic [BW-1:0]   pa, pb;
    logic [2*BW-1:0] pr;
    bit              prev_full  = 0;
    bit              prev_valid = 0;
    bit              prev_ready = 0;
    bit              exp_start;
    bit              exp_valid;
    int              n_starts = 0;

    // Monitor: sample away from the rising edge and compare against the model
    always @(negedge clk) begin
        if (!reset_n) begin
            chk("rst_a", 64'(a), 64'(0));
            chk("rst_b", 64'(b), 64'(0));
            chk("rst_mat_valid", 64'(mat_valid), 64'(0));
            chk("rst_start", 64'(start), 64'(0));
            chk("rst_in_ready", 64'(in_ready), 64'(0));
            beats.delete();
            exp_q.delete();
            held_a     = '0;
            held_b     = '0;
            prev_full  = 0;
            prev_valid = 0;
            prev_ready = 0;
        end else begin
            exp_start = prev_full && (!prev_valid || prev_ready);
            chk("start", 64'(start), 64'(exp_start));
            if (exp_start) begin
                pr = exp_q.pop_front();
                held_a = pr[2*BW-1:BW];
                held_b = pr[BW-1:0];
                n_starts++;
            end
            chk("a", 64'(a), 64'(held_a));
            chk("b", 64'(b), 64'(held_b));
            exp_valid = exp_start ? 1'b1 : (prev_valid && !prev_ready);
            chk("mat_valid", 64'(mat_valid), 64'(exp_valid));
            chk("in_ready", 64'(in_ready), 64'(exp_q.size() == 0));
            prev_full  = (exp_q.size() != 0);
            prev_valid = exp_valid;
            prev_ready = mat_ready;
            if (in_valid && in_ready) begin
                beats.push_back(in_data);
                if (beats.size() == 2 * NN) begin
                    for (int i = 0; i < NN; i++) begin
                        pa[i*W +: W] = beats[i];
                        pb[i*W +: W] = beats[NN + i];
                    end
                    exp_q.push_back({pa, pb});
                    beats.delete();
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] d);
        int  g;
        bit  ok;
        g  = 0;
        ok = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!ok && g < 100) begin
            ok = in_ready;
            step();
            g++;
        end
        in_valid = 1'b0;
        if (!ok) chk("send_timeout", 64'(0), 64'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, cyc, lows, s0;
        bit took;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        mat_ready = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;
        step();

        // Reset mid-B: five beats then reset discards the partial load
        for (int i = 0; i < 5; i++) send(W'(8'hA0 + i));
        reset_n = 1'b0;
        repeat (2) step();
        chk("t1_mat_valid", 64'(mat_valid), 64'(0));
        reset_n = 1'b1;
        step();

        // First pair 1..8 after reset, element 1 must land at A[0,0]
        for (int i = 1; i <= 8; i++) send(W'(i));
        step();
        chk("t2_start", 64'(start), 64'(1));
        chk("t2_a", 64'(a), 64'(32'h04030201));
        chk("t2_b", 64'(b), 64'(32'h08070605));
        chk("t2_mat_valid", 64'(mat_valid), 64'(1));
        step();
        chk("t2_start_off", 64'(start), 64'(0));

        // Held output blocks the shadow: loader stalls in FULL until consumed
        for (int i = 9; i <= 16; i++) send(W'(i));
        repeat (2) step();
        chk("t3_in_ready", 64'(in_ready), 64'(0));
        chk("t3_a_held", 64'(a), 64'(32'h04030201));
        chk("t3_b_held", 64'(b), 64'(32'h08070605));
        mat_ready = 1'b1;
        step();
        mat_ready = 1'b0;
        chk("t3_start", 64'(start), 64'(1));
        chk("t3_a", 64'(a), 64'(32'h0C0B0A09));
        chk("t3_b", 64'(b), 64'(32'h100F0E0D));
        chk("t3_mat_valid", 64'(mat_valid), 64'(1));

        // Consume while shadow is empty: valid drops, data held
        mat_ready = 1'b1;
        step();
        mat_ready = 1'b0;
        chk("t5_mat_valid", 64'(mat_valid), 64'(0));
        chk("t5_a", 64'(a), 64'(32'h0C0B0A09));
        step();

        // Random gaps on both sides over four pairs
        s0  = n_starts;
        acc = 0;
        cyc = 0;
        while (acc < 8 * NN && cyc < 2000) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = W'($urandom);
            mat_ready = 1'($urandom_range(0, 1));
            took = in_valid && in_ready;
            step();
            if (took) acc++;
            cyc++;
        end
        chk("t4_accepts", 64'(acc), 64'(8 * NN));
        in_valid  = 1'b0;
        mat_ready = 1'b1;
        repeat (4) step();
        chk("t4_starts", 64'(n_starts - s0), 64'(4));

        // Continuous streaming with consumer always ready: one stall cycle per pair
        s0   = n_starts;
        acc  = 0;
        cyc  = 0;
        lows = 0;
        in_valid = 1'b1;
        while (acc < 6 * NN && cyc < 500) begin
            in_data = W'($urandom);
            took = in_ready;
            if (!in_ready) lows++;
            step();
            if (took) acc++;
            cyc++;
        end
        in_valid = 1'b0;
        if (!in_ready) lows++;
        repeat (3) step();
        chk("t6_stall_cycles", 64'(lows), 64'(3));
        chk("t6_starts", 64'(n_starts - s0), 64'(3));

        mat_ready = 1'b0;
        repeat (3) step();
        chk("drain_pending", 64'(exp_q.size()), 64'(0));
        chk("drain_partial", 64'(beats.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
